// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation select,
// FSM states and the mfhi/mflo request codes used by the register file.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  localparam logic [1:0] MOVE_NONE = 2'b00;
  localparam logic [1:0] MOVE_HIGH = 2'b01;
  localparam logic [1:0] MOVE_LOW  = 2'b10;

endpackage

// File: rtl/mult_div_unit_md_step.sv
// One iteration of the multiply/divide datapath: right-shifting shift-add for
// multiply, left-shifting restoring shift-subtract for divide.
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] shreg_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             op_is_div_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum    = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = {acc_i, shreg_i[WIDTH-1]};
    // When the subtract succeeds the true difference is below the divisor,
    // so the low WIDTH bits of the modular difference are exact.
    diff   = rem_sh[WIDTH-1:0] - opnd_i;
    if (op_is_div_i) begin
      if (rem_sh >= {1'b0, opnd_i}) begin
        acc_o   = diff;
        shreg_o = {shreg_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o   = rem_sh[WIDTH-1:0];
        shreg_o = {shreg_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o   = sum[WIDTH:1];
      shreg_o = {sum[0], shreg_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: unsigned magnitudes are iterated one
// bit per cycle, then a single FIX cycle applies sign correction and writes HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [1:0]       sig_mf_hi_lo,
  output logic [WIDTH-1:0] hi_reg,
  output logic [WIDTH-1:0] lo_reg,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] acc_q, acc_d, shreg_q, shreg_d, opnd_q, opnd_d;
  logic             sa_q, sa_d, sb_q, sb_d, is_div_q, is_div_d, div0_q, div0_d;
  logic [WIDTH-1:0] step_acc, step_sh;

  function automatic logic signed [WIDTH-1:0] neg_w(input logic signed [WIDTH-1:0] x);
    return -x;
  endfunction

  function automatic logic signed [2*WIDTH-1:0] neg_2w(input logic signed [2*WIDTH-1:0] x);
    return -x;
  endfunction

  md_step #(.WIDTH(WIDTH)) u_step (
    .acc_i       (acc_q),
    .shreg_i     (shreg_q),
    .opnd_i      (opnd_q),
    .op_is_div_i (is_div_q),
    .acc_o       (step_acc),
    .shreg_o     (step_sh)
  );

  logic             is_signed;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    shreg_d   = shreg_q;
    opnd_d    = opnd_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    is_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
    prod_fix  = (sa_q ^ sb_q) ? neg_2w({acc_q, shreg_q}) : {acc_q, shreg_q};
    quo_fix   = div0_q ? '1 : ((sa_q ^ sb_q) ? neg_w(shreg_q) : shreg_q);
    rem_fix   = sa_q ? neg_w(acc_q) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              sa_d     = is_signed & rs_val[WIDTH-1];
              sb_d     = is_signed & rt_val[WIDTH-1];
              shreg_d  = sa_d ? neg_w(rs_val) : rs_val;
              opnd_d   = sb_d ? neg_w(rt_val) : rt_val;
              acc_d    = '0;
              is_div_d = (md_op == MD_DIV) || (md_op == MD_DIVU);
              div0_d   = (rt_val == '0);
              cnt_d    = CNT_W'(ITER - 1);
              busy_d   = 1'b1;
              state_d  = S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        acc_d   = step_acc;
        shreg_d = step_sh;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Iteration datapath carries no reset; it is fully loaded when an op is accepted.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    shreg_q  <= shreg_d;
    opnd_q   <= opnd_d;
    sa_q     <= sa_d;
    sb_q     <= sb_d;
    is_div_q <= is_div_d;
    div0_q   <= div0_d;
  end

  assign hi_reg = hi_q;
  assign lo_reg = lo_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign stall  = busy_q && (start || (sig_mf_hi_lo != MOVE_NONE));

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, latency,
// stall behaviour, mthi/mtlo moves and reset abort.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic [1:0]  sig_mf_hi_lo;
  logic [31:0] hi_reg, lo_reg;
  logic        busy, done, stall;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .md_op        (md_op),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .sig_mf_hi_lo (sig_mf_hi_lo),
    .hi_reg       (hi_reg),
    .lo_reg       (lo_reg),
    .busy         (busy),
    .done         (done),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch an op at the next edge and run 40 further cycles, counting busy/done samples.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busy_cyc, output int done_cnt);
    busy_cyc = 0;
    done_cnt = 0;
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      tick();
    end
  endtask

  int  bc, dc, stall_cyc, guard;
  bit  hold_ok, done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0;
    rs_val = '0; rt_val = '0; sig_mf_hi_lo = MOVE_NONE;
    tick();
    tick();
    reset = 1'b0;
    check("rst_hi", hi_reg, 32'h0);
    check("rst_lo", lo_reg, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);

    do_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc);
    check("multu_max_hi", hi_reg, 32'hFFFFFFFE);
    check("multu_max_lo", lo_reg, 32'h00000001);
    check("multu_busy_cycles", bc, 32'd33);
    check("multu_done_count", dc, 32'd1);

    do_op(MD_MULT, 32'hFFFFFFF9, 32'd3, bc, dc);
    check("mult_neg_hi", hi_reg, 32'hFFFFFFFF);
    check("mult_neg_lo", lo_reg, 32'hFFFFFFEB);
    check("mult_done_count", dc, 32'd1);

    do_op(MD_MULTU, 32'hFFFFFFF9, 32'd3, bc, dc);
    check("multu_big_hi", hi_reg, 32'h00000002);
    check("multu_big_lo", lo_reg, 32'hFFFFFFEB);

    do_op(MD_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, bc, dc);
    check("mult_negneg_hi", hi_reg, 32'h0);
    check("mult_negneg_lo", lo_reg, 32'd15);

    do_op(MD_DIV, 32'hFFFFFFF9, 32'd2, bc, dc);
    check("div_neg_lo", lo_reg, 32'hFFFFFFFD);
    check("div_neg_hi", hi_reg, 32'hFFFFFFFF);
    check("div_busy_cycles", bc, 32'd33);

    do_op(MD_DIVU, 32'd100, 32'd0, bc, dc);
    check("divu_zero_lo", lo_reg, 32'hFFFFFFFF);
    check("divu_zero_hi", hi_reg, 32'd100);
    check("divu_zero_done", dc, 32'd1);

    do_op(MD_DIV, 32'hFFFFFFFB, 32'd0, bc, dc);
    check("div_zero_lo", lo_reg, 32'hFFFFFFFF);
    check("div_zero_hi", hi_reg, 32'hFFFFFFFB);

    do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, bc, dc);
    check("div_ovf_lo", lo_reg, 32'h80000000);
    check("div_ovf_hi", hi_reg, 32'h0);

    do_op(MD_DIVU, 32'hFFFFFFF9, 32'd2, bc, dc);
    check("divu_lo", lo_reg, 32'h7FFFFFFC);
    check("divu_hi", hi_reg, 32'd1);

    // mthi then mtlo on consecutive cycles
    start = 1'b1; md_op = MD_MTHI; rs_val = 32'h1234;
    tick();
    check("mthi_hi", hi_reg, 32'h1234);
    check("mthi_busy", {31'b0, busy}, 32'h0);
    md_op = MD_MTLO; rs_val = 32'h5678;
    tick();
    start = 1'b0;
    check("mtlo_lo", lo_reg, 32'h5678);
    check("mtlo_hi_kept", hi_reg, 32'h1234);
    check("mtlo_busy", {31'b0, busy}, 32'h0);

    // undefined op is ignored
    start = 1'b1; md_op = 3'd7; rs_val = 32'hDEAD; rt_val = 32'h1;
    tick();
    start = 1'b0;
    check("undef_busy", {31'b0, busy}, 32'h0);
    check("undef_hi", hi_reg, 32'h1234);
    check("undef_lo", lo_reg, 32'h5678);

    // div 100/7 with mflo and a queued mthi held during the iteration
    start = 1'b1; md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
    tick();
    md_op = MD_MTHI; rs_val = 32'hAAAA; sig_mf_hi_lo = MOVE_LOW;
    stall_cyc = 0;
    hold_ok   = 1'b1;
    guard     = 0;
    while (busy && guard < 40) begin
      if (stall) stall_cyc++;
      if (hi_reg !== 32'h1234 || lo_reg !== 32'h5678) hold_ok = 1'b0;
      guard++;
      tick();
    end
    check("stall_busy_end", {31'b0, busy}, 32'h0);
    check("stall_cycles", stall_cyc, 32'd33);
    check("stall_hold_hilo", {31'b0, hold_ok}, 32'h1);
    check("stall_div_lo", lo_reg, 32'd14);
    check("stall_div_hi", hi_reg, 32'd2);
    check("stall_released", {31'b0, stall}, 32'h0);
    tick();
    start = 1'b0; sig_mf_hi_lo = MOVE_NONE;
    check("queued_mthi_hi", hi_reg, 32'hAAAA);
    check("queued_mthi_lo", lo_reg, 32'd14);
    check("queued_mthi_busy", {31'b0, busy}, 32'h0);

    // reset asserted at edge 10 of a mult
    start = 1'b1; md_op = MD_MULT; rs_val = 32'd6; rt_val = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("abort_busy_before", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_hi", hi_reg, 32'h0);
    check("abort_lo", lo_reg, 32'h0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) done_seen = 1'b1;
      tick();
    end
    check("abort_no_done", {31'b0, done_seen}, 32'h0);

    do_op(MD_MULT, 32'd6, 32'd7, bc, dc);
    check("post_abort_hi", hi_reg, 32'h0);
    check("post_abort_lo", lo_reg, 32'd42);
    check("post_abort_done", dc, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
